// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for lock with timeout/retries, qualifies lock, then releases sys_rst.
// Optional lock-loss counter output loss_count is built when PLL_SUP_LOSS_CNT_EN is defined.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked_in,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
`ifdef PLL_SUP_LOSS_CNT_EN
  output logic [7:0]                         loss_count,
`endif
  output logic                               fail
);

  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_ONE = RW'(1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             sync1_q, sync2_q;
  logic             lock_lost_q, lock_lost_d;
  logic             locked_s;

  // Two-flop synchronizer: the only consumer of the raw PLL lock input.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked_in;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          cnt_d   = '0;
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + RETRY_ONE;
            state_d = S_RESET_PLL;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          lock_lost_d = 1'b1;
          state_d     = S_RESET_PLL;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_RESET_PLL;
      end
    endcase
  end

  assign pll_rst     = (state_q == S_RESET_PLL) || (state_q == S_FAIL);
  assign ready       = (state_q == S_RUN);
  assign sys_rst     = !ready;
  assign fail        = (state_q == S_FAIL);
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost_q && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; expectations are queued when stimulus is applied and popped when observed.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;
  localparam int RW = $clog2(MR + 1);
  // Input edge to ready: two synchronizer stages, one WAIT_LOCK decision, ST qualification cycles.
  localparam int LOCK_TO_READY = 2 + 1 + ST;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked_in = 1'b0;
  logic          pll_rst, sys_rst, ready, lock_lost, fail;
  logic [RW-1:0] retry_count;
`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0]    loss_count;
`endif

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(ST),
    .MAX_RETRIES(MR),
    .CNT_W(20)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked_in(pll_locked_in),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .lock_lost(lock_lost),
    .retry_count(retry_count),
`ifdef PLL_SUP_LOSS_CNT_EN
    .loss_count(loss_count),
`endif
    .fail(fail)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic sys_low_seen;
  logic prst_seen;
  int   lost_pulses;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input string tag, input logic [31:0] exp_v, input logic [31:0] obs);
    expect_val(tag, exp_v);
    check_next(obs);
  endtask

  // Counts consecutive cycles (from the current negedge) where pll_rst equals want.
  task automatic run_len(input logic want, output int n);
    n = 0;
    while (pll_rst === want && n < 500) begin
      if (sys_rst !== 1'b1) sys_low_seen = 1'b1;
      if (lock_lost === 1'b1) lost_pulses++;
      n++;
      @(negedge refclk);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 500) begin
      if (pll_rst === 1'b1) prst_seen = 1'b1;
      n++;
      @(negedge refclk);
    end
  endtask

  task automatic wait_lost(output int n);
    n = 0;
    while (lock_lost !== 1'b1 && n < 100) begin
      n++;
      @(negedge refclk);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pll_locked_in = 1'b0;
    repeat (3) @(negedge refclk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    step({pfx, "_pll_rst"}, 32'd1, 32'(pll_rst));
    step({pfx, "_sys_rst"}, 32'd1, 32'(sys_rst));
    step({pfx, "_ready"},   32'd0, 32'(ready));
    step({pfx, "_fail"},    32'd0, 32'(fail));
    step({pfx, "_retry"},   32'd0, 32'(retry_count));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge refclk);

    // Nominal lock
    apply_reset();
    check_reset_outputs("rst1");
    step("rst1_lock_lost", 32'd0, 32'(lock_lost));
    rst = 1'b0;
    expect_val("t1_pll_rst_pulse", RP);
    run_len(1'b1, n);
    check_next(n);
    repeat (2) @(negedge refclk);
    pll_locked_in = 1'b1;
    expect_val("t1_lock_to_ready", LOCK_TO_READY);
    wait_ready(n);
    check_next(n);
    step("t1_sys_rst", 32'd0, 32'(sys_rst));
    step("t1_retry", 32'd0, 32'(retry_count));

    // Glitch during qualification (locked_s low while the stable count is 5)
    apply_reset();
    rst = 1'b0;
    run_len(1'b1, n);
    repeat (2) @(negedge refclk);
    pll_locked_in = 1'b1;
    repeat (6) @(negedge refclk);
    pll_locked_in = 1'b0;
    @(negedge refclk);
    pll_locked_in = 1'b1;
    prst_seen = 1'b0;
    expect_val("t3_recover_to_ready", LOCK_TO_READY);
    wait_ready(n);
    check_next(n);
    step("t3_no_pll_rst", 32'd0, 32'(prst_seen));
    step("t3_retry", 32'd0, 32'(retry_count));

    // Loss in RUN
    repeat (2) @(negedge refclk);
    pll_locked_in = 1'b0;
    expect_val("t4_drop_to_lock_lost", 32'd3);
    wait_lost(n);
    check_next(n);
    step("t4_ready_at_loss", 32'd0, 32'(ready));
    step("t4_sys_rst_at_loss", 32'd1, 32'(sys_rst));
    lost_pulses = 0;
    expect_val("t4_pll_rst_pulse", RP);
    run_len(1'b1, n);
    check_next(n);
    step("t4_lock_lost_width", 32'd1, 32'(lost_pulses));
    pll_locked_in = 1'b1;
    expect_val("t4_relock_to_ready", LOCK_TO_READY);
    wait_ready(n);
    check_next(n);
    step("t4_retry", 32'd0, 32'(retry_count));

    // Lock timeout with retries, then FAIL; rst clears FAIL
    apply_reset();
    rst = 1'b0;
    sys_low_seen = 1'b0;
    for (int i = 0; i <= MR; i++) begin
      expect_val($sformatf("t2_pulse%0d", i), RP);
      run_len(1'b1, n);
      check_next(n);
      expect_val($sformatf("t2_gap%0d", i), TO);
      run_len(1'b0, n);
      check_next(n);
      if (i < MR) step($sformatf("t2_retry%0d", i), 32'(i + 1), 32'(retry_count));
    end
    step("t2_fail", 32'd1, 32'(fail));
    step("t2_retry_at_fail", 32'(MR), 32'(retry_count));
    n = 0;
    repeat (30) begin
      if (pll_rst === 1'b1) n++;
      if (sys_rst !== 1'b1) sys_low_seen = 1'b1;
      @(negedge refclk);
    end
    step("t2_pll_rst_stuck", 32'd30, 32'(n));
    step("t2_sys_rst_held", 32'd0, 32'(sys_low_seen));
    rst = 1'b1;
    @(negedge refclk);
    check_reset_outputs("t5_from_fail");

    // Reset in WAIT_LOCK with retry_count=1
    rst = 1'b0;
    pll_locked_in = 1'b0;
    run_len(1'b1, n);
    run_len(1'b0, n);
    step("t5_retry_before", 32'd1, 32'(retry_count));
    run_len(1'b1, n);
    repeat (5) @(negedge refclk);
    step("t5_in_wait_lock", 32'd0, 32'(pll_rst));
    rst = 1'b1;
    @(negedge refclk);
    check_reset_outputs("t5_from_wait");

`ifdef PLL_SUP_LOSS_CNT_EN
    // Loss counter: three losses, then saturation
    apply_reset();
    step("t6_loss_reset", 32'd0, 32'(loss_count));
    rst = 1'b0;
    for (int k = 1; k <= 303; k++) begin
      pll_locked_in = 1'b1;
      wait_ready(n);
      pll_locked_in = 1'b0;
      wait_lost(n);
      @(negedge refclk);
      if (k == 3) step("t6_loss_3", 32'd3, 32'(loss_count));
      if (k == 255) step("t6_loss_255", 32'd255, 32'(loss_count));
    end
    step("t6_loss_saturated", 32'd255, 32'(loss_count));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
